// File: rtl/cvxif_arb_pkg.sv
// Shared types for the CV-X-IF coprocessor arbiter: issue FSM states, ownership entries, result payload.
package cvxif_arb_pkg;

    localparam int unsigned MaxCoproW  = 3;
    localparam int unsigned MaxIdWidth = 8;
    localparam int unsigned MaxXlen    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic                 busy;
        logic                 wb;
        logic [MaxCoproW-1:0] owner;
    } owner_entry_t;

    typedef struct packed {
        logic [MaxIdWidth-1:0] id;
        logic [MaxXlen-1:0]    data;
        logic [4:0]            rd;
        logic                  we;
    } result_t;

endpackage

// File: rtl/cvxif_result_rr_arb.sv
// Round-robin result arbiter with a grant lock that holds the selection while the core stalls.
module cvxif_result_rr_arb #(
    parameter int unsigned NrCopro = 2,
    localparam int unsigned IdxW   = (NrCopro > 1) ? $clog2(NrCopro) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NrCopro-1:0] req_i,
    input  logic               stall_i,
    input  logic               advance_i,
    output logic [NrCopro-1:0] grant_oh_o,
    output logic [IdxW-1:0]    grant_idx_o,
    output logic               grant_valid_o
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            lock_q;
    logic [IdxW-1:0] pick_idx;
    logic            pick_found;

    // First requester at or after the pointer, wrapping around
    always_comb begin
        int unsigned j;
        j          = 0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned off = 0; off < NrCopro; off++) begin
            j = (32'(ptr_q) + off) % NrCopro;
            if (!pick_found && req_i[IdxW'(j)]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(j);
            end
        end
    end

    assign grant_idx_o   = lock_q ? lock_idx_q : pick_idx;
    assign grant_valid_o = lock_q ? req_i[lock_idx_q] : pick_found;
    assign grant_oh_o    = grant_valid_o ? (NrCopro'(1) << grant_idx_o) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= stall_i;
            lock_idx_q <= grant_idx_o;
            if (advance_i) begin
                ptr_q <= (grant_idx_o == IdxW'(NrCopro - 1)) ? '0 : grant_idx_o + IdxW'(1);
            end
        end
    end

endmodule

// File: rtl/cvxif_copro_arbiter.sv
// Shares one CV-X-IF port between NrCopro coprocessors: sequential issue probing, ID ownership, result RR.
// Build option: define CVXIF_ARB_OUTREG_EN to register the result path (one extra cycle of latency).
module cvxif_copro_arbiter
    import cvxif_arb_pkg::*;
#(
    parameter int unsigned NrCopro = 2,
    parameter int unsigned IdWidth = 3,
    parameter int unsigned XLEN    = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       x_issue_valid_i,
    output logic                       x_issue_ready_o,
    input  logic [IdWidth-1:0]         x_issue_id_i,
    input  logic [31:0]                x_issue_instr_i,
    output logic                       x_issue_accept_o,
    output logic                       x_issue_writeback_o,
    input  logic                       x_commit_valid_i,
    input  logic [IdWidth-1:0]         x_commit_id_i,
    input  logic                       x_commit_kill_i,
    output logic                       x_result_valid_o,
    input  logic                       x_result_ready_i,
    output logic [IdWidth-1:0]         x_result_id_o,
    output logic [XLEN-1:0]            x_result_data_o,
    output logic [4:0]                 x_result_rd_o,
    output logic                       x_result_we_o,
    output logic [NrCopro-1:0]         cp_issue_valid_o,
    input  logic [NrCopro-1:0]         cp_issue_ready_i,
    input  logic [NrCopro-1:0]         cp_issue_accept_i,
    input  logic [NrCopro-1:0]         cp_issue_writeback_i,
    output logic [IdWidth-1:0]         cp_issue_id_o,
    output logic [31:0]                cp_issue_instr_o,
    output logic [NrCopro-1:0]         cp_commit_valid_o,
    output logic [IdWidth-1:0]         cp_commit_id_o,
    output logic                       cp_commit_kill_o,
    input  logic [NrCopro-1:0]         cp_result_valid_i,
    output logic [NrCopro-1:0]         cp_result_ready_o,
    input  logic [NrCopro*IdWidth-1:0] cp_result_id_i,
    input  logic [NrCopro*XLEN-1:0]    cp_result_data_i,
    input  logic [NrCopro*5-1:0]       cp_result_rd_i,
    input  logic [NrCopro-1:0]         cp_result_we_i
);

    localparam int unsigned IdxW  = (NrCopro > 1) ? $clog2(NrCopro) : 1;
    localparam int unsigned Depth = 2 ** IdWidth;

    issue_state_e    state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            issue_rec;
    owner_entry_t    tbl_q [Depth];

    logic               commit_hit, free_commit, free_result, res_hs;
    logic [IdWidth-1:0] res_id;

    // Issue FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Issue FSM: probe coprocessors in order until one accepts or all reject
    always_comb begin
        state_d             = state_q;
        idx_d               = idx_q;
        cp_issue_valid_o    = '0;
        x_issue_ready_o     = 1'b0;
        x_issue_accept_o    = 1'b0;
        x_issue_writeback_o = 1'b0;
        issue_rec           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (x_issue_valid_i) begin
                    state_d = PROBE;
                    idx_d   = '0;
                end
            end
            PROBE: begin
                cp_issue_valid_o[idx_q] = 1'b1;
                if (cp_issue_ready_i[idx_q]) begin
                    if (cp_issue_accept_i[idx_q]) begin
                        x_issue_ready_o     = 1'b1;
                        x_issue_accept_o    = 1'b1;
                        x_issue_writeback_o = cp_issue_writeback_i[idx_q];
                        issue_rec           = 1'b1;
                        state_d             = DONE;
                    end else if (idx_q == IdxW'(NrCopro - 1)) begin
                        x_issue_ready_o = 1'b1;
                        state_d         = DONE;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cp_issue_id_o    = (state_q == PROBE) ? x_issue_id_i : '0;
    assign cp_issue_instr_o = (state_q == PROBE) ? x_issue_instr_i : '0;

    // Commit routed only to the owner of a live ID
    assign commit_hit  = x_commit_valid_i & tbl_q[x_commit_id_i].busy;
    assign free_commit = commit_hit & (x_commit_kill_i | ~tbl_q[x_commit_id_i].wb);
    assign free_result = res_hs & tbl_q[res_id].busy & tbl_q[res_id].wb;

    always_comb begin
        cp_commit_valid_o = '0;
        for (int unsigned c = 0; c < NrCopro; c++) begin
            cp_commit_valid_o[c] = commit_hit && (tbl_q[x_commit_id_i].owner == MaxCoproW'(c));
        end
    end

    assign cp_commit_id_o   = rst_ni ? x_commit_id_i : '0;
    assign cp_commit_kill_o = rst_ni & x_commit_kill_i;

    // Ownership table; a new issue overrides a free of the same ID
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (issue_rec && x_issue_id_i == IdWidth'(i)) begin
                    tbl_q[i] <= '{busy: 1'b1, wb: cp_issue_writeback_i[idx_q], owner: MaxCoproW'(idx_q)};
                end else if ((free_commit && x_commit_id_i == IdWidth'(i)) ||
                             (free_result && res_id == IdWidth'(i))) begin
                    tbl_q[i].busy <= 1'b0;
                end
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        issue_rec |-> (!tbl_q[x_issue_id_i].busy ||
                       (free_commit && x_commit_id_i == x_issue_id_i) ||
                       (free_result && res_id == x_issue_id_i)));

    // Result arbitration
    logic [NrCopro-1:0] grant_oh;
    logic [IdxW-1:0]    grant_idx;
    logic               grant_valid, arb_stall, arb_advance;
    logic [IdWidth-1:0] sel_id;
    logic [XLEN-1:0]    sel_data;
    logic [4:0]         sel_rd;
    logic               sel_we;

    assign sel_id   = cp_result_id_i[32'(grant_idx)*IdWidth +: IdWidth];
    assign sel_data = cp_result_data_i[32'(grant_idx)*XLEN +: XLEN];
    assign sel_rd   = cp_result_rd_i[32'(grant_idx)*5 +: 5];
    assign sel_we   = cp_result_we_i[grant_idx];

    cvxif_result_rr_arb #(.NrCopro(NrCopro)) u_rr_arb (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (cp_result_valid_i),
        .stall_i       (arb_stall),
        .advance_i     (arb_advance),
        .grant_oh_o    (grant_oh),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

`ifdef CVXIF_ARB_OUTREG_EN
    result_t stage_q;
    logic    stage_valid_q, load_ok, up_hs;

    // Stage accepts a new result when empty or draining this cycle
    assign load_ok           = ~stage_valid_q | x_result_ready_i;
    assign up_hs             = rst_ni & grant_valid & load_ok;
    assign cp_result_ready_o = (rst_ni & load_ok) ? grant_oh : '0;
    assign arb_stall         = 1'b0;
    assign arb_advance       = up_hs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_valid_q <= 1'b0;
            stage_q       <= '0;
        end else if (up_hs) begin
            stage_valid_q <= 1'b1;
            stage_q       <= '{id: MaxIdWidth'(sel_id), data: MaxXlen'(sel_data), rd: sel_rd, we: sel_we};
        end else if (x_result_ready_i) begin
            stage_valid_q <= 1'b0;
        end
    end

    assign x_result_valid_o = stage_valid_q;
    assign x_result_id_o    = IdWidth'(stage_q.id);
    assign x_result_data_o  = XLEN'(stage_q.data);
    assign x_result_rd_o    = stage_q.rd;
    assign x_result_we_o    = stage_q.we;
    assign res_hs           = stage_valid_q & x_result_ready_i;
    assign res_id           = IdWidth'(stage_q.id);
`else
    assign x_result_valid_o  = rst_ni & grant_valid;
    assign x_result_id_o     = x_result_valid_o ? sel_id : '0;
    assign x_result_data_o   = x_result_valid_o ? sel_data : '0;
    assign x_result_rd_o     = x_result_valid_o ? sel_rd : '0;
    assign x_result_we_o     = x_result_valid_o & sel_we;
    assign cp_result_ready_o = (rst_ni & x_result_ready_i) ? grant_oh : '0;
    assign arb_stall         = x_result_valid_o & ~x_result_ready_i;
    assign arb_advance       = x_result_valid_o & x_result_ready_i;
    assign res_hs            = arb_advance;
    assign res_id            = sel_id;
`endif

endmodule
